// File: rtl/fft_mem_ctrl.sv
// Load/column/row/unload sequencer for the 64-word radix-8 FFT working memory.
// Define FFT_CTRL_DIGIT_REV_EN to unload in natural frequency order (transposed addressing).
module fft_mem_ctrl #(
    parameter int DATA_WD       = 20,
    parameter int BFLY_MAX_WAIT = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic               din_vld_i,
    input  logic [DATA_WD-1:0] din_dat_i,
    input  logic               bfly_vld_i,
    output logic               busy_o,
    output logic [1:0]         stage_o,
    output logic [2:0]         vec_idx_o,
    output logic               done_o,
    output logic               err_o,
    output logic               dim_sel_o,
    output logic               rd_vld_1x8_o,
    output logic [2:0]         rd_addr_1x8_o,
    output logic               wr_vld_1x8_o,
    output logic [2:0]         wr_addr_1x8_o,
    output logic               rd_vld_1x1_o,
    output logic [5:0]         rd_addr_1x1_o,
    output logic               wr_vld_1x1_o,
    output logic [5:0]         wr_addr_1x1_o,
    output logic [DATA_WD-1:0] wr_dat_1x1_o
);
    localparam int TMR_WD = $clog2(BFLY_MAX_WAIT + 1);

    typedef enum logic [2:0] {
        IDLE, LOAD, COL_RD, COL_WAIT, ROW_RD, ROW_WAIT, UNLOAD
    } state_t;

    state_t             state;
    logic [2:0]         rd_cnt;
    logic [2:0]         wr_cnt;
    logic [5:0]         ld_cnt;
    logic [TMR_WD-1:0]  timer;
    logic               done_q;
    logic               err_q;

    logic in_col, in_row, in_stage, in_rd, in_unload, ld_wr, bfly_wr;
    logic [5:0] unload_addr;

    always_comb begin
        in_col    = (state == COL_RD) || (state == COL_WAIT);
        in_row    = (state == ROW_RD) || (state == ROW_WAIT);
        in_stage  = in_col || in_row;
        in_rd     = (state == COL_RD) || (state == ROW_RD);
        in_unload = (state == UNLOAD);
        ld_wr     = (state == LOAD) && din_vld_i;
        bfly_wr   = in_stage && bfly_vld_i;
`ifdef FFT_CTRL_DIGIT_REV_EN
        unload_addr = {ld_cnt[2:0], ld_cnt[5:3]};
`else
        unload_addr = ld_cnt;
`endif
    end

    // ld_cnt doubles as the unload counter; it has wrapped back to 0 by the end of LOAD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            rd_cnt <= '0;
            wr_cnt <= '0;
            ld_cnt <= '0;
            timer  <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        state <= LOAD;
                        err_q <= 1'b0;
                    end
                end
                LOAD: begin
                    if (din_vld_i) begin
                        ld_cnt <= ld_cnt + 6'd1;
                        if (ld_cnt == 6'd63) state <= COL_RD;
                    end
                end
                COL_RD, ROW_RD: begin
                    rd_cnt <= rd_cnt + 3'd1;
                    if (bfly_vld_i) wr_cnt <= wr_cnt + 3'd1;
                    if (rd_cnt == 3'd7) state <= (state == COL_RD) ? COL_WAIT : ROW_WAIT;
                end
                COL_WAIT, ROW_WAIT: begin
                    if (bfly_vld_i) begin
                        wr_cnt <= wr_cnt + 3'd1;
                        timer  <= '0;
                        if (wr_cnt == 3'd7) state <= (state == COL_WAIT) ? ROW_RD : UNLOAD;
                    end else if (timer == TMR_WD'(BFLY_MAX_WAIT - 1)) begin
                        state  <= IDLE;
                        err_q  <= 1'b1;
                        rd_cnt <= '0;
                        wr_cnt <= '0;
                        ld_cnt <= '0;
                        timer  <= '0;
                    end else begin
                        timer <= timer + TMR_WD'(1);
                    end
                end
                UNLOAD: begin
                    ld_cnt <= ld_cnt + 6'd1;
                    if (ld_cnt == 6'd63) begin
                        state  <= IDLE;
                        done_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        busy_o        = (state != IDLE);
        stage_o       = in_col ? 2'd1 : in_row ? 2'd2 : in_unload ? 2'd3 : 2'd0;
        vec_idx_o     = in_rd ? rd_cnt : '0;
        done_o        = done_q;
        err_o         = err_q;
        dim_sel_o     = in_col;
        rd_vld_1x8_o  = in_rd;
        rd_addr_1x8_o = in_rd ? rd_cnt : '0;
        wr_vld_1x8_o  = bfly_wr;
        wr_addr_1x8_o = bfly_wr ? wr_cnt : '0;
        rd_vld_1x1_o  = in_unload;
        rd_addr_1x1_o = in_unload ? unload_addr : '0;
        wr_vld_1x1_o  = ld_wr;
        wr_addr_1x1_o = ld_wr ? ld_cnt : '0;
        wr_dat_1x1_o  = ld_wr ? din_dat_i : '0;
    end
endmodule

// File: tb/tb_fft_mem_ctrl.sv
// Bench for fft_mem_ctrl: per-run table of butterfly behaviours, traces checked against a phase-level timeline model.
module tb_fft_mem_ctrl;
    localparam int DW   = 20;
    localparam int MAXW = 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start_i = 1'b0, din_vld_i = 1'b0, bfly_vld_i = 1'b0;
    logic [DW-1:0] din_dat_i = '0;
    logic          busy_o, done_o, err_o, dim_sel_o;
    logic [1:0]    stage_o;
    logic [2:0]    vec_idx_o, rd_addr_1x8_o, wr_addr_1x8_o;
    logic          rd_vld_1x8_o, wr_vld_1x8_o, rd_vld_1x1_o, wr_vld_1x1_o;
    logic [5:0]    rd_addr_1x1_o, wr_addr_1x1_o;
    logic [DW-1:0] wr_dat_1x1_o;

    fft_mem_ctrl #(.DATA_WD(DW), .BFLY_MAX_WAIT(MAXW)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .din_vld_i(din_vld_i),
        .din_dat_i(din_dat_i), .bfly_vld_i(bfly_vld_i), .busy_o(busy_o),
        .stage_o(stage_o), .vec_idx_o(vec_idx_o), .done_o(done_o), .err_o(err_o),
        .dim_sel_o(dim_sel_o), .rd_vld_1x8_o(rd_vld_1x8_o), .rd_addr_1x8_o(rd_addr_1x8_o),
        .wr_vld_1x8_o(wr_vld_1x8_o), .wr_addr_1x8_o(wr_addr_1x8_o),
        .rd_vld_1x1_o(rd_vld_1x1_o), .rd_addr_1x1_o(rd_addr_1x1_o),
        .wr_vld_1x1_o(wr_vld_1x1_o), .wr_addr_1x1_o(wr_addr_1x1_o),
        .wr_dat_1x1_o(wr_dat_1x1_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int lat;
        int n_col;
        int n_row;
        bit gap;
        bit stray;
        bit exp_err;
        int exp_done;
    } vec_t;
    vec_t tbl[7];

    int ld_cyc[$], ld_dat[$], w1_cyc[$], w1_addr[$], w1_dat[$];
    int r8_cyc[$], r8_addr[$], r8_dim[$], r8_stage[$], r8_vec[$];
    int w8_cyc[$], w8_addr[$], w8_dim[$], r1_cyc[$], r1_addr[$], r1_stage[$];
    int done_cyc[$], b_cyc[$], due[$];
    int e_r8_cyc[$], e_r8_addr[$], e_r8_dim[$], e_r8_stage[$];
    int e_w8_cyc[$], e_w8_addr[$], e_w8_dim[$], e_r1_cyc[$], e_r1_addr[$];

    function automatic bit chk(input string name, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
            return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic longint all_out();
        return longint'({busy_o, stage_o, vec_idx_o, done_o, err_o, dim_sel_o,
                         rd_vld_1x8_o, rd_addr_1x8_o, wr_vld_1x8_o, wr_addr_1x8_o,
                         rd_vld_1x1_o, rd_addr_1x1_o, wr_vld_1x1_o, wr_addr_1x1_o,
                         wr_dat_1x1_o});
    endfunction

    function automatic int exp_unload_addr(input int k);
`ifdef FFT_CTRL_DIGIT_REV_EN
        return (k % 8) * 8 + k / 8;
`else
        return k;
`endif
    endfunction

    function automatic bit has_bfly(input int c);
        foreach (b_cyc[i]) if (b_cyc[i] == c) return 1'b1;
        return 1'b0;
    endfunction

    task automatic clear_traces();
        ld_cyc.delete(); ld_dat.delete(); w1_cyc.delete(); w1_addr.delete(); w1_dat.delete();
        r8_cyc.delete(); r8_addr.delete(); r8_dim.delete(); r8_stage.delete(); r8_vec.delete();
        w8_cyc.delete(); w8_addr.delete(); w8_dim.delete();
        r1_cyc.delete(); r1_addr.delete(); r1_stage.delete();
        done_cyc.delete(); b_cyc.delete(); due.delete();
        e_r8_cyc.delete(); e_r8_addr.delete(); e_r8_dim.delete(); e_r8_stage.delete();
        e_w8_cyc.delete(); e_w8_addr.delete(); e_w8_dim.delete();
        e_r1_cyc.delete(); e_r1_addr.delete();
    endtask

    // One complete operation from start_i; the butterfly answers the first n reads of each stage after lat cycles.
    task automatic run_op(input vec_t v, input string tag);
        int  sent = 0, col_iss = 0, row_iss = 0, busy_low = -1, err_low = 0, rw_c = -1;
        int  rs, e = -1, abort = -1, cnt, run, exp_done_c = -1;
        bit  fin = 1'b0, b;
        clear_traces();
        if (v.stray) begin
            @(posedge clk); #1;
            bfly_vld_i = 1'b1;
            @(negedge clk);
            void'(chk({tag, " idle bfly wr8"}, wr_vld_1x8_o, 0));
            void'(chk({tag, " idle bfly busy"}, busy_o, 0));
        end
        for (int c = 0; c < 1500 && !fin; c++) begin
            @(posedge clk); #1;
            start_i   = (c == 0) || (v.stray && (c == 20 || c == rw_c));
            din_vld_i = 1'b0;
            if (c >= 1 && sent < 64) din_vld_i = v.gap ? ($urandom_range(0, 3) != 0) : 1'b1;
            din_dat_i = DW'($urandom);
            bfly_vld_i = 1'b0;
            if (due.size() > 0 && due[0] == c) begin
                void'(due.pop_front());
                bfly_vld_i = 1'b1;
                b_cyc.push_back(c);
            end
            if (v.stray && c == 10) bfly_vld_i = 1'b1;
            @(negedge clk);
            if (din_vld_i) begin
                ld_cyc.push_back(c); ld_dat.push_back(int'(din_dat_i)); sent++;
            end
            if (c == 1) void'(chk({tag, " err cleared by start"}, err_o, 0));
            if (v.stray && c == 10) void'(chk({tag, " load bfly wr8"}, wr_vld_1x8_o, 0));
            if (wr_vld_1x1_o) begin
                w1_cyc.push_back(c); w1_addr.push_back(int'(wr_addr_1x1_o));
                w1_dat.push_back(int'(wr_dat_1x1_o));
            end
            if (rd_vld_1x8_o) begin
                r8_cyc.push_back(c); r8_addr.push_back(int'(rd_addr_1x8_o));
                r8_dim.push_back(int'(dim_sel_o)); r8_stage.push_back(int'(stage_o));
                r8_vec.push_back(int'(vec_idx_o));
                if (dim_sel_o) begin
                    if (col_iss < v.n_col) due.push_back(c + v.lat);
                    col_iss++;
                end else begin
                    if (row_iss < v.n_row) due.push_back(c + v.lat);
                    row_iss++;
                end
            end
            if (wr_vld_1x8_o) begin
                w8_cyc.push_back(c); w8_addr.push_back(int'(wr_addr_1x8_o));
                w8_dim.push_back(int'(dim_sel_o));
            end
            if (rd_vld_1x1_o) begin
                r1_cyc.push_back(c); r1_addr.push_back(int'(rd_addr_1x1_o));
                r1_stage.push_back(int'(stage_o));
            end
            if (done_o) done_cyc.push_back(c);
            if (busy_low < 0 && c > 0 && !busy_o) begin
                busy_low = c; err_low = int'(err_o);
            end
            if (v.stray && rw_c < 0 && busy_o && stage_o == 2'd2 && !rd_vld_1x8_o) rw_c = c + 1;
            if (busy_low >= 0 && due.size() == 0 && c >= busy_low + 3) fin = 1'b1;
        end
        start_i = 1'b0; din_vld_i = 1'b0; bfly_vld_i = 1'b0;
        void'(chk({tag, " finished within budget"}, fin, 1));

        // Timeline model: phase boundaries from the inputs the bench drove.
        if (ld_cyc.size() == 64) begin
            rs = ld_cyc[63] + 1;
            for (int s = 0; s < 2; s++) begin
                for (int k = 0; k < 8; k++) begin
                    e_r8_cyc.push_back(rs + k); e_r8_addr.push_back(k);
                    e_r8_dim.push_back(s == 0); e_r8_stage.push_back(s + 1);
                end
                cnt = 0; run = 0; e = -1;
                for (int cc = rs; cc < rs + 400; cc++) begin
                    b = has_bfly(cc);
                    if (b) begin
                        e_w8_cyc.push_back(cc); e_w8_addr.push_back(cnt); e_w8_dim.push_back(s == 0);
                        cnt++;
                        if (cnt == 8) begin e = cc; break; end
                    end
                    if (cc >= rs + 8) begin
                        run = b ? 0 : run + 1;
                        if (run == MAXW) begin abort = cc + 1; break; end
                    end
                end
                if (abort >= 0 || e < 0) break;
                rs = e + 1;
            end
            if (abort < 0 && e >= 0) begin
                for (int k = 0; k < 64; k++) begin
                    e_r1_cyc.push_back(rs + k); e_r1_addr.push_back(exp_unload_addr(k));
                end
                exp_done_c = rs + 64;
            end
        end

        if (chk({tag, " load write count"}, w1_cyc.size(), 64))
            foreach (w1_cyc[k])
                if (!chk({tag, $sformatf(" load wr cycle[%0d]", k)}, w1_cyc[k], ld_cyc[k]) ||
                    !chk({tag, $sformatf(" load wr addr[%0d]", k)}, w1_addr[k], k) ||
                    !chk({tag, $sformatf(" load wr data[%0d]", k)}, w1_dat[k], ld_dat[k])) break;
        if (chk({tag, " 1x8 read count"}, r8_cyc.size(), e_r8_cyc.size()))
            foreach (e_r8_cyc[k])
                if (!chk({tag, $sformatf(" rd8 cycle[%0d]", k)}, r8_cyc[k], e_r8_cyc[k]) ||
                    !chk({tag, $sformatf(" rd8 addr[%0d]", k)}, r8_addr[k], e_r8_addr[k]) ||
                    !chk({tag, $sformatf(" rd8 vec_idx[%0d]", k)}, r8_vec[k], e_r8_addr[k]) ||
                    !chk({tag, $sformatf(" rd8 dim_sel[%0d]", k)}, r8_dim[k], e_r8_dim[k]) ||
                    !chk({tag, $sformatf(" rd8 stage[%0d]", k)}, r8_stage[k], e_r8_stage[k])) break;
        if (chk({tag, " 1x8 write count"}, w8_cyc.size(), e_w8_cyc.size()))
            foreach (e_w8_cyc[k])
                if (!chk({tag, $sformatf(" wr8 cycle[%0d]", k)}, w8_cyc[k], e_w8_cyc[k]) ||
                    !chk({tag, $sformatf(" wr8 addr[%0d]", k)}, w8_addr[k], e_w8_addr[k]) ||
                    !chk({tag, $sformatf(" wr8 dim_sel[%0d]", k)}, w8_dim[k], e_w8_dim[k])) break;
        if (chk({tag, " unload read count"}, r1_cyc.size(), e_r1_cyc.size()))
            foreach (e_r1_cyc[k])
                if (!chk({tag, $sformatf(" unload cycle[%0d]", k)}, r1_cyc[k], e_r1_cyc[k]) ||
                    !chk({tag, $sformatf(" unload addr[%0d]", k)}, r1_addr[k], e_r1_addr[k]) ||
                    !chk({tag, $sformatf(" unload stage[%0d]", k)}, r1_stage[k], 3)) break;
        void'(chk({tag, " done pulse count"}, done_cyc.size(), v.exp_done));
        if (done_cyc.size() == 1 && exp_done_c >= 0)
            void'(chk({tag, " done cycle"}, done_cyc[0], exp_done_c));
        void'(chk({tag, " busy fall cycle"}, busy_low, (abort >= 0) ? abort : exp_done_c));
        void'(chk({tag, " err at busy fall"}, err_low, v.exp_err));
        void'(chk({tag, " err from model"}, err_low, (abort >= 0) ? 1 : 0));
        void'(chk({tag, " err sticky in idle"}, err_o, v.exp_err));
    endtask

    // Asynchronous reset while the column reads are being issued.
    task automatic reset_mid_col();
        @(posedge clk); #1;
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        for (int i = 0; i < 64; i++) begin
            din_vld_i = 1'b1; din_dat_i = DW'(i);
            @(posedge clk); #1;
        end
        din_vld_i = 1'b0;
        @(negedge clk);
        void'(chk("rst-mid rd8 valid after load", rd_vld_1x8_o, 1));
        void'(chk("rst-mid rd8 first addr", rd_addr_1x8_o, 0));
        void'(chk("rst-mid dim_sel col", dim_sel_o, 1));
        repeat (3) @(posedge clk);
        #1;
        din_vld_i = 1'b1; bfly_vld_i = 1'b1;
        #1;
        void'(chk("rst-mid rd8 addr before reset", rd_addr_1x8_o, 3));
        #1;
        rst_n = 1'b0;
        #1;
        void'(chk("rst-mid outputs cleared async", all_out(), 0));
        @(posedge clk); #3;
        din_vld_i = 1'b0; bfly_vld_i = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        void'(chk("rst-mid outputs after release", all_out(), 0));
    endtask

    initial begin
        vec_t rec;
        tbl[0] = '{3,  8, 8, 1'b0, 1'b0, 1'b0, 1};
        tbl[1] = '{1,  8, 8, 1'b1, 1'b1, 1'b0, 1};
        tbl[2] = '{5,  5, 8, 1'b0, 1'b0, 1'b1, 0};
        tbl[3] = '{71, 8, 8, 1'b1, 1'b0, 1'b0, 1};
        tbl[4] = '{72, 8, 8, 1'b0, 1'b0, 1'b1, 0};
        tbl[5] = '{3,  8, 3, 1'b0, 1'b0, 1'b1, 0};
        tbl[6] = '{12, 8, 8, 1'b1, 1'b1, 1'b0, 1};

        #1;
        void'(chk("reset outputs", all_out(), 0));
        #11;
        rst_n = 1'b1;
        @(negedge clk);
        void'(chk("outputs after reset release", all_out(), 0));

        foreach (tbl[i]) run_op(tbl[i], $sformatf("run%0d", i));

        reset_mid_col();
        rec = '{3, 8, 8, 1'b1, 1'b0, 1'b0, 1};
        run_op(rec, "post-reset run");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fft_mem_ctrl.md
Name: fft_mem_ctrl

Overview:
Sequencer for the 8x8 (64-word) FFT working memory in the 64-point radix-8 FFT.
- Drives the memory's 1x1 and 1x8 read/write ports and the row/col select through five phases: load 64 samples, column butterfly stage, row butterfly stage, unload 64 results, done.
- Owns all memory addressing; sample data and butterfly data flow directly between neighbours and the memory.

Parameters:
DATA_WD, 20, sample width, passed through on the 1x1 write data path
BFLY_MAX_WAIT, 64, cycles allowed in a WAIT state before the stage aborts to IDLE

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
start_i  input  1  one-cycle start pulse; accepted only in IDLE
din_vld_i  input  1  input sample valid during LOAD
din_dat_i  input  DATA_WD  input sample
bfly_vld_i  input  1  butterfly result vector valid (one per issued vector, in issue order)
busy_o  output  1  high in every state except IDLE
stage_o  output  2  0 idle/load, 1 column stage, 2 row stage, 3 unload; drives twiddle select
vec_idx_o  output  3  index of the vector currently issued to the butterfly
done_o  output  1  one-cycle pulse at end of unload
err_o  output  1  sticky timeout flag, cleared by the next accepted start_i
dim_sel_o  output  1  memory row/col select: 0 row, 1 col
rd_vld_1x8_o  output  1  1x8 read request
rd_addr_1x8_o  output  3  1x8 read address
wr_vld_1x8_o  output  1  1x8 write request
wr_addr_1x8_o  output  3  1x8 write address
rd_vld_1x1_o  output  1  1x1 read request
rd_addr_1x1_o  output  6  1x1 read address
wr_vld_1x1_o  output  1  1x1 write request
wr_addr_1x1_o  output  6  1x1 write address
wr_dat_1x1_o  output  DATA_WD  1x1 write data

Behaviour:
- Reset: state IDLE. All outputs 0. Counters rd_cnt, wr_cnt, ld_cnt and timer cleared.
- FSM: IDLE -> LOAD -> COL_RD -> COL_WAIT -> ROW_RD -> ROW_WAIT -> UNLOAD -> IDLE.
- IDLE: start_i moves to LOAD and clears err_o. start_i in any other state is ignored.
- LOAD: each din_vld_i produces a combinational write: wr_vld_1x1_o=1, wr_addr_1x1_o=ld_cnt, wr_dat_1x1_o=din_dat_i; ld_cnt increments. Gaps in din_vld_i are allowed. The write with ld_cnt=63 moves the FSM to COL_RD.
- COL_RD: dim_sel_o=1 and stage_o=1.
  - rd_vld_1x8_o=1 with rd_addr_1x8_o=rd_cnt=0..7, one vector per cycle, 8 back-to-back cycles; vec_idx_o=rd_cnt.
  - After addr 7 is issued, go to COL_WAIT.
- Column write-back, in COL_RD or COL_WAIT: each bfly_vld_i gives wr_vld_1x8_o=1 (combinational) and wr_addr_1x8_o=wr_cnt; wr_cnt increments.
- COL_WAIT exits to ROW_RD when wr_cnt wraps 7->0, i.e. after the 8th result.
  - This guarantees every column write lands before any row read.
- ROW_RD / ROW_WAIT: identical to the column stage except dim_sel_o=0 and stage_o=2.
  - The 8th row result moves the FSM to UNLOAD.
- UNLOAD: rd_vld_1x1_o=1 for 64 consecutive cycles. Address order is given under Optional Feature.
  - Memory read latency is 1 cycle, so result k appears on the memory 1x1 output one cycle after its request.
  - done_o pulses in the cycle after the address-63 request, aligned with the last read data. The FSM enters IDLE in that same cycle.
- bfly_vld_i outside COL_RD/COL_WAIT/ROW_RD/ROW_WAIT is ignored: no write is issued.
- Simultaneous events:
  - bfly_vld_i may coincide with rd_vld_1x8_o. Reads and writes use independent counters.
  - The write address never equals an address still pending read in the same stage, because results return in order after their reads.
- Timeout: the timer counts cycles spent in a WAIT state without bfly_vld_i and resets on each bfly_vld_i. At BFLY_MAX_WAIT: err_o=1, FSM goes to IDLE, counters clear.
- Reset mid-operation: immediate return to the reset state. Memory contents are not guaranteed.
- Counters are 3/6-bit modulo; wrap-around is the stage-termination condition, with no extra compare width.

Optional Feature:
- Macro: FFT_CTRL_DIGIT_REV_EN.
- Defined: UNLOAD address = {u_cnt[2:0], u_cnt[5:3]}, i.e. the transpose, so outputs emerge in natural frequency order X[0..63].
- Undefined: UNLOAD address = u_cnt, giving digit-reversed order. Downstream logic reorders.

Test Plan:
1. Reset then start_i, with 64 back-to-back din_vld_i samples 0..63 -> wr_addr_1x1_o sequences 0..63; FSM reaches COL_RD the next cycle; rd_addr_1x8_o 0..7 with dim_sel_o=1.
2. Butterfly model with 3-cycle latency returning 8 results -> wr_addr_1x8_o 0..7 with dim_sel_o=1; the first row read occurs strictly after the 8th column write; ROW stage repeats with dim_sel_o=0 and stage_o=2.
3. Full run with FFT_CTRL_DIGIT_REV_EN defined -> unload addresses 0,8,16,...,56,1,9,...,63; done_o pulses exactly once, 1 cycle after the address-63 request; busy_o falls in that cycle. Undefined -> addresses 0..63.
4. start_i asserted during LOAD and ROW_WAIT, plus a stray bfly_vld_i in IDLE and LOAD -> no state change, no 1x8 write issued.
5. Butterfly returns only 5 of 8 column results -> err_o=1 after 64 idle cycles; FSM in IDLE with busy_o=0; next start_i clears err_o.
6. rst_n asserted in the middle of COL_RD -> all outputs 0 asynchronously; after release, a normal run completes correctly.
